// File: rtl/bgd_pixel_sequencer.sv
// Background pixel path: coordinate -> ROM address -> palette index -> faded RGB, 3-cycle latency.
// Optional build macro BGD_TESTPAT_EN adds test_en, which replaces ROM data with an XOR checkerboard.
module bgd_pixel_sequencer #(
   parameter int IMG_W            = 320,
   parameter int IMG_H            = 240,
   parameter int SCALE_SHIFT      = 1,
   parameter int ADDR_W           = 17,
   parameter int FADE_STEP_FRAMES = 4
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic              vde,
   input  logic              frame_start,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [3:0]        rom_q,
   output logic [3:0]        pal_index,
   input  logic [3:0]        pal_red,
   input  logic [3:0]        pal_green,
   input  logic [3:0]        pal_blue,
   input  logic [1:0]        fade_cmd,
   output logic              fade_busy,
   output logic [3:0]        fade_level,
   output logic [3:0]        red,
   output logic [3:0]        green,
   output logic [3:0]        blue
`ifdef BGD_TESTPAT_EN
   ,
   input  logic              test_en
`endif
);

   localparam int CNT_W = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FADE_STEP_FRAMES - 1);

   typedef enum logic [1:0] {S_DARK, S_FADE_IN, S_BRIGHT, S_FADE_OUT} state_t;

   logic [9:0]        w_sx;
   logic [9:0]        w_sy;
   logic              w_in_img;
   logic [ADDR_W-1:0] w_addr;
   logic [3:0]        w_pal_next;

   logic [ADDR_W-1:0] r_rom_addr;
   logic [3:0]        r_pal_index;
   logic              r_vld_p1;
   logic              r_vld_p2;
   logic [3:0]        r_red;
   logic [3:0]        r_green;
   logic [3:0]        r_blue;
   logic [3:0]        r_tp_p1;

   state_t            r_state;
   logic [3:0]        r_fade_level;
   logic              r_fade_busy;
   logic [CNT_W-1:0]  r_cnt;

   // 8-bit product keeps level 15 as identity and level 0 as black
   function automatic logic [3:0] f_scale(input logic [3:0] c, input logic [3:0] lvl);
      logic [7:0] p;
      p = {4'b0, c} * ({4'b0, lvl} + 8'd1);
      return p[7:4];
   endfunction

   assign w_sx     = DrawX >> SCALE_SHIFT;
   assign w_sy     = DrawY >> SCALE_SHIFT;
   assign w_in_img = (32'(w_sx) < IMG_W) && (32'(w_sy) < IMG_H);
   assign w_addr   = ADDR_W'(32'(w_sy) * IMG_W + 32'(w_sx));

`ifdef BGD_TESTPAT_EN
   assign w_pal_next = test_en ? r_tp_p1 : rom_q;
`else
   assign w_pal_next = rom_q;
`endif

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_rom_addr  <= '0;
         r_pal_index <= '0;
         r_vld_p1    <= 1'b0;
         r_vld_p2    <= 1'b0;
         r_red       <= '0;
         r_green     <= '0;
         r_blue      <= '0;
         r_tp_p1     <= '0;
      end else begin
         if (w_in_img) r_rom_addr <= w_addr;
         r_vld_p1    <= vde && w_in_img;
         r_tp_p1     <= w_sx[3:0] ^ w_sy[3:0];
         // stage 2: ROM data for the stage-1 address is on rom_q now
         r_pal_index <= w_pal_next;
         r_vld_p2    <= r_vld_p1;
         // stage 3: palette output belongs to r_pal_index
         r_red       <= r_vld_p2 ? f_scale(pal_red,   r_fade_level) : 4'd0;
         r_green     <= r_vld_p2 ? f_scale(pal_green, r_fade_level) : 4'd0;
         r_blue      <= r_vld_p2 ? f_scale(pal_blue,  r_fade_level) : 4'd0;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state      <= S_BRIGHT;
         r_fade_level <= 4'd15;
         r_fade_busy  <= 1'b0;
         r_cnt        <= '0;
      end else begin
         case (r_state)
            S_DARK: begin
               r_fade_level <= 4'd0;
               if (fade_cmd == 2'b01) begin
                  r_state     <= S_FADE_IN;
                  r_cnt       <= '0;
                  r_fade_busy <= 1'b1;
               end
            end
            S_FADE_IN: begin
               if (frame_start) begin
                  if (r_cnt == CNT_LAST) begin
                     r_cnt        <= '0;
                     r_fade_level <= r_fade_level + 4'd1;
                     if (r_fade_level == 4'd14) begin
                        r_state     <= S_BRIGHT;
                        r_fade_busy <= 1'b0;
                     end
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            S_BRIGHT: begin
               r_fade_level <= 4'd15;
               if (fade_cmd == 2'b10) begin
                  r_state     <= S_FADE_OUT;
                  r_cnt       <= '0;
                  r_fade_busy <= 1'b1;
               end
            end
            S_FADE_OUT: begin
               if (frame_start) begin
                  if (r_cnt == CNT_LAST) begin
                     r_cnt        <= '0;
                     r_fade_level <= r_fade_level - 4'd1;
                     if (r_fade_level == 4'd1) begin
                        r_state     <= S_DARK;
                        r_fade_busy <= 1'b0;
                     end
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            default: r_state <= S_BRIGHT;
         endcase
      end
   end

   assign rom_addr   = r_rom_addr;
   assign pal_index  = r_pal_index;
   assign red        = r_red;
   assign green      = r_green;
   assign blue       = r_blue;
   assign fade_busy  = r_fade_busy;
   assign fade_level = r_fade_level;

endmodule

// File: tb/tb_bgd_pixel_sequencer.sv
// Directed bench for bgd_pixel_sequencer: pipeline latency, masking, and the fade controller.
module tb_bgd_pixel_sequencer;

   logic        Clk;
   logic        Reset_n;
   logic [9:0]  DrawX;
   logic [9:0]  DrawY;
   logic        vde;
   logic        frame_start;
   logic [16:0] rom_addr;
   logic [3:0]  rom_q;
   logic [3:0]  pal_index;
   logic [3:0]  pal_red;
   logic [3:0]  pal_green;
   logic [3:0]  pal_blue;
   logic [1:0]  fade_cmd;
   logic        fade_busy;
   logic [3:0]  fade_level;
   logic [3:0]  red;
   logic [3:0]  green;
   logic [3:0]  blue;
`ifdef BGD_TESTPAT_EN
   logic        test_en;
`endif

   int n_cmp;
   int n_fail;

   bgd_pixel_sequencer dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .DrawX       (DrawX),
      .DrawY       (DrawY),
      .vde         (vde),
      .frame_start (frame_start),
      .rom_addr    (rom_addr),
      .rom_q       (rom_q),
      .pal_index   (pal_index),
      .pal_red     (pal_red),
      .pal_green   (pal_green),
      .pal_blue    (pal_blue),
      .fade_cmd    (fade_cmd),
      .fade_busy   (fade_busy),
      .fade_level  (fade_level),
      .red         (red),
      .green       (green),
      .blue        (blue)
`ifdef BGD_TESTPAT_EN
      ,
      .test_en     (test_en)
`endif
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // ROM data follows the registered address; low nibble of 965 is 5, of 966 is 6
   assign rom_q = rom_addr[3:0];

   always_comb begin
      pal_red   = 4'hF;
      pal_green = 4'hF;
      pal_blue  = 4'hF;
      case (pal_index)
         4'd5: begin pal_red = 4'h2; pal_green = 4'hA; pal_blue = 4'hD; end
         4'd6: begin pal_red = 4'h2; pal_green = 4'hB; pal_blue = 4'hE; end
         default: ;
      endcase
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic frame_pulse();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      step();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_rgb(input string tag, input logic [3:0] er, input logic [3:0] eg, input logic [3:0] eb);
      chk({tag, ".rgb"}, {20'd0, red, green, blue}, {20'd0, er, eg, eb});
   endtask

   initial begin
      n_cmp       = 0;
      n_fail      = 0;
      Reset_n     = 1'b0;
      DrawX       = '0;
      DrawY       = '0;
      vde         = 1'b0;
      frame_start = 1'b0;
      fade_cmd    = 2'b00;
`ifdef BGD_TESTPAT_EN
      test_en     = 1'b0;
`endif
      step();
      step();
      chk("rst.rom_addr", 32'(rom_addr), 32'd0);
      chk("rst.pal_index", 32'(pal_index), 32'd0);
      chk_rgb("rst", 4'h0, 4'h0, 4'h0);
      chk("rst.busy", 32'(fade_busy), 32'd0);
      chk("rst.level", 32'(fade_level), 32'd15);

      Reset_n = 1'b1;
      DrawX   = 10'd10;
      DrawY   = 10'd6;
      vde     = 1'b1;
      step();
      chk("e1.rom_addr", 32'(rom_addr), 32'd965);
      step();
      chk("e2.pal_index", 32'(pal_index), 32'd5);
      chk_rgb("e2.not_yet", 4'h0, 4'h0, 4'h0);
      step();
      chk_rgb("e3.pixel", 4'h2, 4'hA, 4'hD);

      DrawX = 10'd700;
      step();
      chk("oob.addr_hold", 32'(rom_addr), 32'd965);
      step();
      step();
      chk_rgb("oob", 4'h0, 4'h0, 4'h0);

      DrawX = 10'd10;
      vde   = 1'b0;
      step();
      step();
      step();
      chk_rgb("invisible", 4'h0, 4'h0, 4'h0);

      DrawX = 10'd12;
      vde   = 1'b1;
      step();
      step();
      step();
      chk("px6.rom_addr", 32'(rom_addr), 32'd966);
      chk_rgb("px6.l15", 4'h2, 4'hB, 4'hE);

      fade_cmd = 2'b10;
      step();
      fade_cmd = 2'b00;
      chk("fo.busy", 32'(fade_busy), 32'd1);
      chk("fo.level0", 32'(fade_level), 32'd15);
      for (int i = 0; i < 3; i++) frame_pulse();
      chk("fo.level_p3", 32'(fade_level), 32'd15);
      frame_pulse();
      chk("fo.level_p4", 32'(fade_level), 32'd14);
      chk_rgb("fo.l14", 4'h1, 4'hA, 4'hD);
      for (int i = 0; i < 55; i++) frame_pulse();
      chk("fo.level_p59", 32'(fade_level), 32'd1);
      chk("fo.busy_p59", 32'(fade_busy), 32'd1);
      frame_pulse();
      chk("fo.level_p60", 32'(fade_level), 32'd0);
      chk("fo.busy_p60", 32'(fade_busy), 32'd0);
      chk_rgb("dark.px6", 4'h0, 4'h0, 4'h0);
      DrawX = 10'd10;
      step();
      step();
      step();
      chk_rgb("dark.px5", 4'h0, 4'h0, 4'h0);

      fade_cmd = 2'b10;
      step();
      fade_cmd = 2'b00;
      frame_pulse();
      chk("dark.ign10.busy", 32'(fade_busy), 32'd0);
      chk("dark.ign10.level", 32'(fade_level), 32'd0);

      fade_cmd    = 2'b01;
      frame_start = 1'b1;
      step();
      fade_cmd    = 2'b00;
      frame_start = 1'b0;
      step();
      chk("fi.busy", 32'(fade_busy), 32'd1);
      for (int i = 0; i < 3; i++) frame_pulse();
      chk("fi.level_p3", 32'(fade_level), 32'd0);
      frame_pulse();
      chk("fi.level_p4", 32'(fade_level), 32'd1);
      fade_cmd = 2'b10;
      step();
      fade_cmd = 2'b00;
      chk("fi.ign10.busy", 32'(fade_busy), 32'd1);
      for (int i = 0; i < 55; i++) frame_pulse();
      chk("fi.level_p59", 32'(fade_level), 32'd14);
      chk("fi.busy_p59", 32'(fade_busy), 32'd1);
      frame_pulse();
      chk("fi.level_p60", 32'(fade_level), 32'd15);
      chk("fi.busy_p60", 32'(fade_busy), 32'd0);
      chk_rgb("bright.px5", 4'h2, 4'hA, 4'hD);

      fade_cmd = 2'b01;
      step();
      fade_cmd = 2'b00;
      for (int i = 0; i < 4; i++) frame_pulse();
      chk("bright.ign01.busy", 32'(fade_busy), 32'd0);
      chk("bright.ign01.level", 32'(fade_level), 32'd15);

      fade_cmd = 2'b10;
      step();
      fade_cmd = 2'b00;
      for (int i = 0; i < 32; i++) frame_pulse();
      chk("mid.level7", 32'(fade_level), 32'd7);
      chk_rgb("mid.l7", 4'h1, 4'h5, 4'h6);
      #2;
      Reset_n = 1'b0;
      #1;
      chk("arst.rom_addr", 32'(rom_addr), 32'd0);
      chk("arst.pal_index", 32'(pal_index), 32'd0);
      chk_rgb("arst", 4'h0, 4'h0, 4'h0);
      chk("arst.busy", 32'(fade_busy), 32'd0);
      chk("arst.level", 32'(fade_level), 32'd15);
      step();
      step();
      Reset_n = 1'b1;
      step();
      chk("rel.level", 32'(fade_level), 32'd15);
      chk("rel.busy", 32'(fade_busy), 32'd0);
      chk_rgb("rel.e1", 4'h0, 4'h0, 4'h0);
      step();
      step();
      chk_rgb("rel.e3", 4'h2, 4'hA, 4'hD);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/bgd_pixel_sequencer.md
Name: bgd_pixel_sequencer

Overview:
Drives the background image path for the VGA pipeline. It converts the current draw coordinate into a background-ROM address and sequences the synchronous ROM read into the 16-entry background palette lookup. It registers the resulting 12-bit RGB and applies a frame-synchronous fade-in/fade-out brightness controller. It sits between the VGA timing generator and the final pixel mux.

Parameters:
IMG_W, 320, background image width in ROM pixels
IMG_H, 240, background image height in ROM pixels
SCALE_SHIFT, 1, right shift applied to DrawX/DrawY (1 = 2x upscale)
ADDR_W, 17, ROM address width; must hold IMG_W*IMG_H-1
FADE_STEP_FRAMES, 4, frames per brightness step during a fade (>=1)

Ports:
Clk  in  1  pixel clock
Reset_n  in  1  asynchronous, active-low reset
DrawX  in  10  current pixel column
DrawY  in  10  current pixel row
vde  in  1  1 = visible pixel this cycle
frame_start  in  1  one-cycle pulse once per frame, during vertical blank
rom_addr  out  ADDR_W  background ROM address, registered
rom_q  in  4  ROM data; valid one cycle after rom_addr
pal_index  out  4  palette index, registered
pal_red, pal_green, pal_blue  in  4 each  combinational palette output for pal_index
fade_cmd  in  2  00 none, 01 fade in, 10 fade out, 11 ignored
fade_busy  out  1  1 while a fade is in progress
fade_level  out  4  current brightness level, 0..15
red, green, blue  out  4 each  final registered background colour

Behaviour:
- Reset: the following are driven to 0:
  - rom_addr, pal_index, red/green/blue
  - all pipeline valid/in-image flags
  - fade_busy, frame counter
- Reset: FSM enters BRIGHT and fade_level=15.
- Reset deassertion mid-frame: first valid pixel appears 3 cycles after the first sampled vde=1.
- Pipeline:
  - Edge 1: sx=DrawX>>SCALE_SHIFT and sy=DrawY>>SCALE_SHIFT; rom_addr <= sy*IMG_W+sx; stage-1 flags <= vde and (sx<IMG_W && sy<IMG_H).
  - Edge 2: pal_index <= rom_q; flags advance.
  - Edge 3: RGB registered.
  - Total latency: 3 cycles from DrawX/DrawY/vde to red/green/blue.
- Out-of-image pixels: rom_addr holds its previous value and the pixel is forced to 0.
- Invisible pixels (vde=0): pixel is forced to 0 at the output.
- Arithmetic:
  - Address product is computed at full width and truncated to ADDR_W.
  - Colour out c_o = (c_in*(fade_level+1))>>4 using an 8-bit product, per channel.
  - fade_level=15 passes the colour unchanged; fade_level=0 gives 0 for every input.
- Fade FSM, 4 states:
  - DARK: fade_level=0. fade_cmd=01 -> FADE_IN, frame counter cleared.
  - FADE_IN: fade_busy=1. On frame_start:
    - counter==FADE_STEP_FRAMES-1 -> fade_level+1, counter cleared; otherwise counter+1.
    - If this step makes fade_level reach 15, go to BRIGHT in the same cycle.
  - BRIGHT: fade_level=15. fade_cmd=01 is ignored. fade_cmd=10 -> FADE_OUT, counter cleared.
  - FADE_OUT: mirror of FADE_IN, decrementing; exits to DARK at fade_level 0.
- fade_cmd is ignored while fade_busy=1. fade_cmd=01 in DARK is the only way to leave DARK; fade_cmd=10 in DARK is ignored.
- fade_level changes only on a frame_start edge, so brightness never changes mid-frame.
- A command and frame_start arriving in the same cycle: the command is accepted. That frame_start does not count toward the first step.
- fade_busy is registered. It rises the cycle after command acceptance and falls the cycle after the terminal level is reached.

Optional Feature:
BGD_TESTPAT_EN
- Defined:
  - Adds input port test_en (1 bit).
  - While test_en=1, pal_index <= (sx[3:0]^sy[3:0]) at edge 2 instead of rom_q, producing a checkerboard of all 16 palette entries.
  - Pipeline timing, masking and fade are unchanged.
- Undefined: no test_en port; pal_index always takes rom_q.

Test Plan:
- Reset, then DrawX=10, DrawY=6, vde=1, rom_q returns 4'h5 with palette output (2,A,D) -> rom_addr=3*320+5=965 after 1 edge; pal_index=5 after 2 edges; RGB=(2,A,D) after 3 edges.
- DrawX=700 (sx=350>=IMG_W), vde=1 -> RGB=0 at 3-cycle latency. Separately, vde=0 with a valid coordinate -> RGB=0.
- From BRIGHT, fade_cmd=10 for one cycle, then 4 frame_start pulses:
  - fade_busy=1 after acceptance; fade_level=14 after the 4th pulse.
  - Palette (2,B,E) output becomes (1,A,D) at level 14.
- After FADE_OUT completes (60 frame_starts total) -> fade_level=0, FSM in DARK, fade_busy=0, RGB=0 for all pixels. Then fade_cmd=01 -> fade_level reaches 15 after 60 further frame_starts, FSM in BRIGHT.
- During FADE_IN issue fade_cmd=10 -> ignored, fade_level keeps incrementing. In BRIGHT issue fade_cmd=01 -> no state change.
- Assert Reset_n=0 mid-fade at fade_level=7 -> all outputs 0 immediately; after release fade_level=15, fade_busy=0.
